pwm_capture: RTL and testbench

- Receive-side counterpart to the LED PWM generator. It measures an incoming PWM waveform and reports its high time and period in clk cycles.
- Used for loopback self-check of the PWM generator, and for reading external PWM sources such as fan tach outputs and RC receivers.
- Input is asynchronous to clk, so it is synchronised internally.
- Detects a stuck-at level (0% or 100% duty) with a timeout.

---
 rtl/pwm_capture.sv | 180 ++++++++++++++++++
 tb/tb_pwm_capture.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// Measures an asynchronous PWM input: high time and rise-to-rise period in clk cycles, plus stuck-level detection.
// Latency: meas_valid pulses in the cycle after the 3rd clk edge following a pwm_in rise (2 sync stages + output register).
// Backpressure: none; results are published as one-cycle pulses and hold until the next published measurement.
module pwm_capture #(
    parameter int PWM_INTERVAL = 1200,
    parameter int MAX_PERIOD   = 4800,
    parameter int CW           = $clog2(MAX_PERIOD + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pwm_in,
    output logic [CW-1:0] high_count,
    output logic [CW-1:0] period_count,
    output logic          meas_valid,
    output logic          stuck,
    output logic          stuck_level
);

    // A nominal period longer than the timeout could never be measured.
    if (MAX_PERIOD < 2 || PWM_INTERVAL > MAX_PERIOD) begin : g_param_check
        $error("pwm_capture: need MAX_PERIOD >= 2 and PWM_INTERVAL <= MAX_PERIOD");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } state_e;

    localparam logic [CW-1:0] MAX_C = CW'(MAX_PERIOD);
    localparam logic [CW-1:0] ONE_C = CW'(1);

    state_e        state_q, state_d;
    logic          s1_q, s1_d;
    logic          s2_q, s2_d;
    logic          s_prev_q, s_prev_d;
    // The synchroniser's reset value is not a sample of pwm_in; fill_q[1] marks
    // the first cycle in which s2 genuinely reflects the input.
    logic [1:0]    fill_q, fill_d;
    logic [CW-1:0] per_cnt_q, per_cnt_d;
    logic [CW-1:0] hi_cnt_q, hi_cnt_d;
    logic [CW-1:0] hi_meas_q, hi_meas_d;
    logic [CW-1:0] high_count_q, high_count_d;
    logic [CW-1:0] period_count_q, period_count_d;
    logic          meas_valid_q, meas_valid_d;
    logic          stuck_q, stuck_d;
    logic          stuck_level_q, stuck_level_d;

    logic          rise;
    logic          fall;
    logic          timeout;
    logic [CW-1:0] per_nxt;
    logic [CW-1:0] hi_nxt;

    assign rise = s2_q & ~s_prev_q;
    assign fall = ~s2_q & s_prev_q;

    // An edge in the timeout cycle wins, so a period of exactly MAX_PERIOD is still published.
    assign timeout = ((state_q == HIGH) || (state_q == LOW)) && !rise && !fall && (per_cnt_q == MAX_C);

    // Saturating increments keep the counters from ever wrapping.
    assign per_nxt = (per_cnt_q == MAX_C) ? per_cnt_q : per_cnt_q + ONE_C;
    assign hi_nxt  = (hi_cnt_q == MAX_C) ? hi_cnt_q : hi_cnt_q + ONE_C;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: wait for a trusted low, then track high and low phases.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fill_q[1] && !s2_q) state_d = ARM;
            ARM:     if (rise) state_d = HIGH;
            HIGH:    if (fall) state_d = LOW;
                     else if (timeout) state_d = IDLE;
            LOW:     if (rise) state_d = HIGH;
                     else if (timeout) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Counters, measurement latches and published outputs for the current state.
    always_comb begin
        s1_d           = pwm_in;
        s2_d           = s1_q;
        s_prev_d       = s2_q;
        fill_d         = {fill_q[0], 1'b1};
        per_cnt_d      = per_cnt_q;
        hi_cnt_d       = hi_cnt_q;
        hi_meas_d      = hi_meas_q;
        high_count_d   = high_count_q;
        period_count_d = period_count_q;
        meas_valid_d   = 1'b0;
        stuck_d        = stuck_q;
        stuck_level_d  = stuck_level_q;
        case (state_q)
            ARM: begin
                if (rise) begin
                    per_cnt_d = ONE_C;
                    hi_cnt_d  = ONE_C;
                end
            end
            HIGH: begin
                per_cnt_d = per_nxt;
                hi_cnt_d  = hi_nxt;
                if (fall) begin
                    hi_meas_d = hi_cnt_q;
                end else if (timeout) begin
                    stuck_d       = 1'b1;
                    stuck_level_d = s2_q;
                    per_cnt_d     = '0;
                    hi_cnt_d      = '0;
                end
            end
            LOW: begin
                if (rise) begin
                    period_count_d = per_cnt_q;
                    high_count_d   = hi_meas_q;
                    meas_valid_d   = 1'b1;
                    stuck_d        = 1'b0;
                    per_cnt_d      = ONE_C;
                    hi_cnt_d       = ONE_C;
                end else if (timeout) begin
                    stuck_d       = 1'b1;
                    stuck_level_d = s2_q;
                    per_cnt_d     = '0;
                    hi_cnt_d      = '0;
                end else begin
                    per_cnt_d = per_nxt;
                end
            end
            default: ;
        endcase
    end

    // Synchroniser, counters and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q           <= 1'b0;
            s2_q           <= 1'b0;
            s_prev_q       <= 1'b0;
            fill_q         <= 2'b00;
            per_cnt_q      <= '0;
            hi_cnt_q       <= '0;
            hi_meas_q      <= '0;
            high_count_q   <= '0;
            period_count_q <= '0;
            meas_valid_q   <= 1'b0;
            stuck_q        <= 1'b0;
            stuck_level_q  <= 1'b0;
        end else begin
            s1_q           <= s1_d;
            s2_q           <= s2_d;
            s_prev_q       <= s_prev_d;
            fill_q         <= fill_d;
            per_cnt_q      <= per_cnt_d;
            hi_cnt_q       <= hi_cnt_d;
            hi_meas_q      <= hi_meas_d;
            high_count_q   <= high_count_d;
            period_count_q <= period_count_d;
            meas_valid_q   <= meas_valid_d;
            stuck_q        <= stuck_d;
            stuck_level_q  <= stuck_level_d;
        end
    end

    assign high_count   = high_count_q;
    assign period_count = period_count_q;
    assign meas_valid   = meas_valid_q;
    assign stuck        = stuck_q;
    assign stuck_level  = stuck_level_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: directed and random PWM waveforms against a rise-to-rise reference model.
// Expected measurements come from the driven waveform's own edge times (period = rise-to-rise, high = rise-to-fall).
// Stuck detection, reset behaviour and minimum-width pulses are checked at exact cycle boundaries.
module tb_pwm_capture;

    localparam int MAX_PERIOD = 4800;
    localparam int CW         = $clog2(MAX_PERIOD + 1);
    localparam int LAT        = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          pwm_in;
    logic [CW-1:0] high_count;
    logic [CW-1:0] period_count;
    logic          meas_valid;
    logic          stuck;
    logic          stuck_level;

    pwm_capture dut (
        .clk          (clk),
        .rst          (rst),
        .pwm_in       (pwm_in),
        .high_count   (high_count),
        .period_count (period_count),
        .meas_valid   (meas_valid),
        .stuck        (stuck),
        .stuck_level  (stuck_level)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int t;
        int h;
        int p;
    } meas_t;

    meas_t obs_q[$];
    meas_t exp_q[$];
    int    dbl_cnt = 0;
    logic  mv_prev = 1'b0;

    // Record every published measurement and any back-to-back meas_valid.
    always @(negedge clk) begin
        if (meas_valid === 1'b1) begin
            obs_q.push_back('{cyc, int'(high_count), int'(period_count)});
            if (mv_prev === 1'b1) dbl_cnt <= dbl_cnt + 1;
        end
        mv_prev <= meas_valid;
    end

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model state: times of the last rise and fall of the driven waveform.
    bit have_prev = 1'b0;
    int prev_rise = 0;
    int last_fall = 0;

    // Drive a level for n cycles; a rise completes the previous period if it fits the timeout.
    task automatic drive(input logic v, input int n);
        if (v && pwm_in === 1'b0) begin
            if (have_prev && (cyc - prev_rise) <= MAX_PERIOD)
                exp_q.push_back('{cyc + LAT, last_fall - prev_rise, cyc - prev_rise});
            have_prev = 1'b1;
            prev_rise = cyc;
        end else if (!v && pwm_in === 1'b1) begin
            last_fall = cyc;
        end
        pwm_in = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic periods(input int h, input int l, input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, h);
            drive(1'b0, l);
        end
    endtask

    task automatic settle_and_compare(input string tag);
        drive(pwm_in, 4);
        chk($sformatf("%s_count", tag), obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            chk($sformatf("%s_time%0d", tag, i), obs_q[i].t, exp_q[i].t);
            chk($sformatf("%s_high%0d", tag, i), obs_q[i].h, exp_q[i].h);
            chk($sformatf("%s_period%0d", tag, i), obs_q[i].p, exp_q[i].p);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_high"}, high_count, 0);
        chk({tag, "_period"}, period_count, 0);
        chk({tag, "_valid"}, meas_valid, 0);
        chk({tag, "_stuck"}, stuck, 0);
        chk({tag, "_level"}, stuck_level, 0);
    endtask

    initial begin
        int n;
        rst    = 1'b1;
        pwm_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;
        drive(1'b0, 10);

        // 300/900 x4: three pulses, 1200 apart, first one LAT after the 2nd rise
        periods(300, 900, 4);
        chk("basic_pulses", obs_q.size(), 3);
        chk("basic_high", high_count, 300);
        chk("basic_period", period_count, 1200);
        chk("basic_stuck", stuck, 0);
        settle_and_compare("basic");

        // duty change 300/900 -> 600/600
        periods(300, 900, 3);
        periods(600, 600, 3);
        chk("duty_high", high_count, 600);
        chk("duty_period", period_count, 1200);
        settle_and_compare("duty");

        // minimum widths
        periods(1, 1, 10);
        chk("min_high", high_count, 1);
        chk("min_period", period_count, 2);
        settle_and_compare("min");
        chk("min_no_back_to_back", dbl_cnt, 0);

        // random waveforms
        for (int i = 0; i < 25; i++)
            periods($urandom_range(1, 400), $urandom_range(1, 400), 1);
        settle_and_compare("rand");

        // stuck high
        periods(300, 900, 2);
        drive(1'b1, 1);
        n = prev_rise + MAX_PERIOD + LAT - 1 - cyc;
        drive(1'b1, n);
        chk("sthi_before", stuck, 0);
        drive(1'b1, 1);
        chk("sthi_stuck", stuck, 1);
        chk("sthi_level", stuck_level, 1);
        chk("sthi_hold_high", high_count, 300);
        chk("sthi_hold_period", period_count, 1200);
        drive(1'b0, 900);
        chk("sthi_still_after_low", stuck, 1);
        periods(300, 900, 1);
        chk("sthi_still_after_arm", stuck, 1);
        drive(1'b1, 300);
        chk("sthi_cleared", stuck, 0);
        chk("sthi_resume_high", high_count, 300);
        chk("sthi_resume_period", period_count, 1200);
        drive(1'b0, 900);
        settle_and_compare("sthi");

        // stuck low
        periods(300, 900, 2);
        n = prev_rise + MAX_PERIOD + LAT - 1 - cyc;
        drive(1'b0, n);
        chk("stlo_before", stuck, 0);
        drive(1'b0, 1);
        chk("stlo_stuck", stuck, 1);
        chk("stlo_level", stuck_level, 0);
        chk("stlo_hold_high", high_count, 300);
        chk("stlo_hold_period", period_count, 1200);
        periods(300, 900, 1);
        chk("stlo_still_after_arm", stuck, 1);
        drive(1'b1, 300);
        chk("stlo_cleared", stuck, 0);
        drive(1'b0, 900);
        settle_and_compare("stlo");

        // reset mid-HIGH, release while pwm_in is still high
        drive(1'b1, 100);
        settle_and_compare("pre_rst");
        rst = 1'b1;
        #2;
        chk_all_zero("async_rst");
        have_prev = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hold_valid", meas_valid, 0);
        rst = 1'b0;
        drive(1'b1, 200);
        drive(1'b0, 900);
        periods(300, 900, 3);
        chk("post_rst_pulses", obs_q.size(), 2);
        chk("post_rst_high", high_count, 300);
        chk("post_rst_period", period_count, 1200);
        settle_and_compare("post_rst");

        chk("no_back_to_back", dbl_cnt, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
